// File: rtl/loop_seq_pkg.sv
// Shared constants for the loop enable sequencer: FSM state encoding,
// fault codes reported on FAULT_CODE, and default parameter values.
package loop_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [1:0] FC_NONE        = 2'b00;
    localparam logic [1:0] FC_ACK_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_DROPOUT     = 2'b10;
    localparam logic [1:0] FC_UNEXPECTED  = 2'b11;

    localparam int DEF_N_LOOPS         = 4;
    localparam int DEF_DEBOUNCE_CYC    = 1000;
    localparam int DEF_ACK_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/loop_debounce.sv
// One loop-state bit: 2-FF synchronizer followed by a debouncer that only
// moves the filtered value after DEBOUNCE_CYC consecutive differing samples.
module loop_debounce
    import loop_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic CLK_100M,
    input  logic RST,
    input  logic loop_state,
    output logic filt
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // synchronizer chain into a single stage.
    always_ff @(posedge CLK_100M or posedge RST) begin
        if (RST) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            filt    <= 1'b0;
        end else begin
            sync_q1 <= loop_state;
            sync_q2 <= sync_q1;
            // Counter is cleared on agreement or on update, so it never passes CNT_LAST.
            if (sync_q2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= sync_q2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/loop_enable_sequencer.sv
// Power-up sequencer for the enable loops: raises LOOP_CNTL one loop at a
// time on acknowledge, holds all loops in RUN, and latches the first fault.
module loop_enable_sequencer
    import loop_seq_pkg::*;
#(
    parameter int N_LOOPS         = DEF_N_LOOPS,
    parameter int DEBOUNCE_CYC    = DEF_DEBOUNCE_CYC,
    parameter int ACK_TIMEOUT_CYC = DEF_ACK_TIMEOUT_CYC,
    localparam int IDX_W          = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
    input  logic               CLK_100M,
    input  logic               RST,
    input  logic               START,
    input  logic               STOP,
    input  logic               FAULT_CLR,
    input  logic [N_LOOPS-1:0] LOOP_STATE,
    output logic [N_LOOPS-1:0] LOOP_CNTL,
    output logic               SEQ_BUSY,
    output logic               SEQ_DONE,
    output logic               FAULT,
    output logic [1:0]         FAULT_CODE,
    output logic [IDX_W-1:0]   FAULT_LOOP
);

    localparam int TMR_W = (ACK_TIMEOUT_CYC > 1) ? $clog2(ACK_TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LOOPS - 1);

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_LOOPS-1:0] v);
        lowest_set = '0;
        for (int i = N_LOOPS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    function automatic logic [N_LOOPS-1:0] thermo(input logic [IDX_W-1:0] k);
        thermo = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            thermo[i] = (IDX_W'(i) <= k);
        end
    endfunction

    logic [N_LOOPS-1:0] filt;

    for (genvar g = 0; g < N_LOOPS; g++) begin : g_deb
        loop_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_loop_debounce (
            .CLK_100M   (CLK_100M),
            .RST        (RST),
            .loop_state (LOOP_STATE[g]),
            .filt       (filt[g])
        );
    end

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_LOOPS-1:0] cntl_d;
    logic [1:0]         code_d;
    logic [IDX_W-1:0]   floop_d;
    logic [N_LOOPS-1:0] below_idx;
    logic [N_LOOPS-1:0] dropped;
    logic               fault_hit;
    logic [1:0]         fault_code_n;
    logic [IDX_W-1:0]   fault_idx_n;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        cntl_d       = LOOP_CNTL;
        code_d       = FAULT_CODE;
        floop_d      = FAULT_LOOP;
        fault_hit    = 1'b0;
        fault_code_n = FC_NONE;
        fault_idx_n  = '0;
        below_idx    = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            below_idx[i] = (IDX_W'(i) < idx_q);
        end
        dropped = below_idx & ~filt;

        case (state_q)
            ST_IDLE: begin
                cntl_d = '0;
                if (|filt) begin
                    fault_hit    = 1'b1;
                    fault_code_n = FC_UNEXPECTED;
                    fault_idx_n  = lowest_set(filt);
                end else if (START) begin
                    state_d = ST_ARM;
                    idx_d   = '0;
                    timer_d = '0;
                    cntl_d  = thermo('0);
                end
            end
            ST_ARM: begin
                // Faults outrank STOP, which outranks the acknowledge.
                if (|dropped) begin
                    fault_hit    = 1'b1;
                    fault_code_n = FC_DROPOUT;
                    fault_idx_n  = lowest_set(dropped);
                end else if (!filt[idx_q] && timer_q == TMR_LAST) begin
                    fault_hit    = 1'b1;
                    fault_code_n = FC_ACK_TIMEOUT;
                    fault_idx_n  = idx_q;
                end else if (STOP) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    timer_d = '0;
                    cntl_d  = '0;
                end else if (filt[idx_q]) begin
                    timer_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        cntl_d  = '1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        cntl_d = thermo(idx_q + 1'b1);
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!(&filt)) begin
                    fault_hit    = 1'b1;
                    fault_code_n = FC_DROPOUT;
                    fault_idx_n  = lowest_set(~filt);
                end else if (STOP) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cntl_d  = '0;
                end
            end
            ST_FAULT: begin
                cntl_d = '0;
                if (FAULT_CLR && !(|filt)) begin
                    state_d = ST_IDLE;
                    code_d  = FC_NONE;
                    floop_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cntl_d  = '0;
            end
        endcase

        if (fault_hit) begin
            state_d = ST_FAULT;
            idx_d   = '0;
            timer_d = '0;
            cntl_d  = '0;
            code_d  = fault_code_n;
            floop_d = fault_idx_n;
        end
    end

    always_ff @(posedge CLK_100M or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            LOOP_CNTL  <= '0;
            FAULT_CODE <= FC_NONE;
            FAULT_LOOP <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            LOOP_CNTL  <= cntl_d;
            FAULT_CODE <= code_d;
            FAULT_LOOP <= floop_d;
        end
    end

    assign SEQ_BUSY = (state_q == ST_ARM);
    assign SEQ_DONE = (state_q == ST_RUN);
    assign FAULT    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_loop_enable_sequencer.sv
// Directed bench for loop_enable_sequencer with a small loop echo model.
module tb_loop_enable_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       fault_clr;
    logic [3:0] loop_state;
    logic [3:0] loop_cntl;
    logic       seq_busy;
    logic       seq_done;
    logic       fault;
    logic [1:0] fault_code;
    logic [1:0] fault_loop;

    int vectors;
    int miscompares;

    // Loop echo model: LOOP_STATE follows LOOP_CNTL a few cycles later.
    logic       echo_en;
    logic [3:0] ack_mask;
    logic [3:0] drop_mask;
    logic [3:0] manual_state;
    logic [3:0] pipe0, pipe1, pipe2;

    loop_enable_sequencer #(
        .N_LOOPS         (4),
        .DEBOUNCE_CYC    (4),
        .ACK_TIMEOUT_CYC (20)
    ) dut (
        .CLK_100M   (clk),
        .RST        (rst),
        .START      (start),
        .STOP       (stop),
        .FAULT_CLR  (fault_clr),
        .LOOP_STATE (loop_state),
        .LOOP_CNTL  (loop_cntl),
        .SEQ_BUSY   (seq_busy),
        .SEQ_DONE   (seq_done),
        .FAULT      (fault),
        .FAULT_CODE (fault_code),
        .FAULT_LOOP (fault_loop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pipe2 = pipe1;
        pipe1 = pipe0;
        pipe0 = loop_cntl;
        loop_state = echo_en ? (pipe2 & ack_mask & ~drop_mask) : manual_state;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (seq_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [3:0] exp_seq [4];
        logic [3:0] prev;
        logic       seen;
        int         step;
        int         n;

        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        fault_clr    = 1'b0;
        loop_state   = 4'h0;
        echo_en      = 1'b0;
        ack_mask     = 4'hF;
        drop_mask    = 4'h0;
        manual_state = 4'h0;
        pipe0        = 4'h0;
        pipe1        = 4'h0;
        pipe2        = 4'h0;
        exp_seq      = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

        // Reset state
        repeat (3) tick();
        check("rst_cntl", {28'd0, loop_cntl}, 32'h0);
        check("rst_flags", {29'd0, seq_busy, seq_done, fault}, 32'h0);
        check("rst_code_loop", {28'd0, fault_code, fault_loop}, 32'h0);
        rst = 1'b0;
        repeat (2) tick();

        // Full power-up sequence with the echo model
        echo_en = 1'b1;
        pulse_start();
        check("start_cntl0", {28'd0, loop_cntl}, 32'h1);
        check("start_busy", {31'd0, seq_busy}, 32'd1);
        prev = loop_cntl;
        step = 1;
        for (int i = 0; i < 200 && !seq_done; i++) begin
            tick();
            if (loop_cntl != prev) begin
                if (step < 4) check("seq_order", {28'd0, loop_cntl}, {28'd0, exp_seq[step]});
                step++;
                prev = loop_cntl;
            end
        end
        check("seq_steps", step, 4);
        check("seq_done", {30'd0, seq_done, fault}, 32'h2);

        // Short dropout on loop 1 is filtered out
        drop_mask = 4'b0010;
        repeat (3) tick();
        drop_mask = 4'b0000;
        repeat (10) tick();
        check("glitch_nofault", {30'd0, fault, seq_done}, 32'h1);

        // Long dropout on loop 1 faults with code 10
        drop_mask = 4'b0010;
        repeat (10) tick();
        drop_mask = 4'b0000;
        check("dropout_fault", {31'd0, fault}, 32'd1);
        check("dropout_code", {30'd0, fault_code}, 32'h2);
        check("dropout_loop", {30'd0, fault_loop}, 32'h1);
        check("dropout_cntl", {28'd0, loop_cntl}, 32'h0);
        repeat (15) tick();
        pulse_clr();
        check("clr_after_dropout", {28'd0, fault, fault_code, seq_done}, 32'h0);

        // Loop 2 never acknowledges: timeout 20 cycles after its enable
        ack_mask = 4'b1011;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (loop_cntl[2]) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("cntl2_rise", {31'd0, seen}, 32'd1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (fault) break;
        end
        check("timeout_cycles", n, 20);
        check("timeout_code", {30'd0, fault_code}, 32'h1);
        check("timeout_loop", {30'd0, fault_loop}, 32'h2);
        tick();
        check("timeout_cntl", {28'd0, loop_cntl}, 32'h0);
        ack_mask = 4'hF;
        repeat (15) tick();
        pulse_clr();
        check("clr_after_timeout", {31'd0, fault}, 32'd0);

        // Loop 3 stuck high in IDLE: unexpected-state fault, START ignored
        echo_en      = 1'b0;
        manual_state = 4'b1000;
        repeat (10) tick();
        pulse_start();
        check("unexp_fault", {31'd0, fault}, 32'd1);
        check("unexp_code", {30'd0, fault_code}, 32'h3);
        check("unexp_loop", {30'd0, fault_loop}, 32'h3);
        check("unexp_cntl", {28'd0, loop_cntl}, 32'h0);
        pulse_clr();
        check("unexp_clr_ignored", {29'd0, fault, fault_code}, 32'h7);
        manual_state = 4'b0000;
        repeat (12) tick();
        pulse_clr();
        check("unexp_clr_taken", {29'd0, fault, fault_code}, 32'h0);

        // STOP and START together while idx = 1
        echo_en = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (loop_cntl == 4'b0011) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("arm_idx1", {31'd0, seen}, 32'd1);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("stop_cntl", {28'd0, loop_cntl}, 32'h0);
        check("stop_flags", {29'd0, seq_busy, seq_done, fault}, 32'h0);
        // Loop 0 still reads back high in IDLE, so the next cycle faults
        tick();
        check("stop_then_unexp", {27'd0, fault, fault_code, fault_loop}, 32'h1C);
        repeat (15) tick();
        pulse_clr();
        check("clr_after_stop", {31'd0, fault}, 32'd0);

        // Asynchronous reset in RUN, then re-sequence from loop 0
        pulse_start();
        wait_done("run_before_rst");
        rst = 1'b1;
        #1;
        check("async_rst_cntl", {28'd0, loop_cntl}, 32'h0);
        check("async_rst_done", {31'd0, seq_done}, 32'd0);
        repeat (5) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("post_rst_idle", {27'd0, fault, loop_cntl}, 32'h0);
        pulse_start();
        check("post_rst_cntl0", {28'd0, loop_cntl}, 32'h1);
        wait_done("post_rst_done");
        check("post_rst_all_on", {28'd0, loop_cntl}, 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/loop_enable_sequencer.md
LOOP_ENABLE_SEQUENCER -- requirements
Module: loop_enable_sequencer

Interface
REQ-001 SHALL have parameter N_LOOPS, default 4, number of enable loops sequenced (bit 0 = PWRENLP, 1 = MTNENLP, 2 = BMENLP, 3 = KVBMENLP).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 1000, consecutive stable cycles before a filtered loop state changes.
REQ-003 SHALL have parameter ACK_TIMEOUT_CYC, default 100000, maximum cycles to wait for a loop's state acknowledge.
REQ-004 SHALL have port CLK_100M  in  1  single clock; all logic in this domain.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port START  in  1  one-cycle request to run the power-up sequence.
REQ-007 SHALL have port STOP  in  1  one-cycle request to drop all loops.
REQ-008 SHALL have port FAULT_CLR  in  1  one-cycle request to leave FAULT.
REQ-009 SHALL have port LOOP_STATE  in  N_LOOPS  raw asynchronous loop state readback.
REQ-010 SHALL have port LOOP_CNTL  out  N_LOOPS  registered loop enable drives.
REQ-011 SHALL have port SEQ_BUSY  out  1  high in ARM.
REQ-012 SHALL have port SEQ_DONE  out  1  high in RUN.
REQ-013 SHALL have port FAULT  out  1  high in FAULT.
REQ-014 SHALL have port FAULT_CODE  out  2  00 none, 01 ack timeout, 10 loop dropout, 11 unexpected state.
REQ-015 SHALL have port FAULT_LOOP  out  clog2(N_LOOPS)  index of the offending loop.

Function
REQ-016 SHALL pass each LOOP_STATE bit through a 2-FF synchronizer, then a debouncer updating filt[i] only after DEBOUNCE_CYC consecutive equal samples.
REQ-017 SHALL implement states IDLE, ARM, RUN, FAULT; current loop index idx and timeout counter are registered.
REQ-018 IDLE: LOOP_CNTL = 0; START with filt = 0 -> ARM, idx = 0, LOOP_CNTL[0] high the cycle after START is sampled.
REQ-019 IDLE: any filt bit high -> FAULT, code 11, FAULT_LOOP = lowest such index; START in that cycle ignored.
REQ-020 ARM: LOOP_CNTL[idx:0] high; filt[idx] high -> idx+1 with timer cleared and LOOP_CNTL[idx+1] high next cycle, or RUN if idx = N_LOOPS-1.
REQ-021 ARM: timer reaching ACK_TIMEOUT_CYC-1 without filt[idx] -> FAULT, code 01, FAULT_LOOP = idx.
REQ-022 ARM: filt[j] low for any j < idx -> FAULT, code 10, FAULT_LOOP = lowest such j.
REQ-023 RUN: all LOOP_CNTL high; any filt bit low -> FAULT, code 10, lowest index reported.
REQ-024 STOP in ARM or RUN -> IDLE, all LOOP_CNTL low next cycle; START outside IDLE ignored.
REQ-025 Priority in one cycle: fault detection > STOP > ack/advance > START.
REQ-026 FAULT: all LOOP_CNTL low next cycle; FAULT, FAULT_CODE, FAULT_LOOP held; FAULT_CLR accepted only when filt = 0 -> IDLE with code 00, else ignored.
REQ-027 Timer width SHALL hold ACK_TIMEOUT_CYC-1 without wrap; debounce counter saturates.

Reset
REQ-028 RST high SHALL immediately force IDLE, LOOP_CNTL = 0, SEQ_BUSY = SEQ_DONE = FAULT = 0, FAULT_CODE = 00, FAULT_LOOP = 0, idx = 0, counters 0.
REQ-029 Synchronizer and filtered state SHALL reset to 0; reset mid-ARM/RUN drops all loops the same cycle (asynchronously).

Structure
REQ-030 Package loop_seq_pkg SHALL hold the state enumeration, FAULT_CODE constants, and default parameter values.
REQ-031 Sub-module loop_debounce (synchronizer + debounce counter, one bit) SHALL be instantiated N_LOOPS times.

Verification (bench: N_LOOPS = 4, DEBOUNCE_CYC = 4, ACK_TIMEOUT_CYC = 20)
REQ-032 START with loop model echoing CNTL after 3 cycles -> LOOP_CNTL 0001, 0011, 0111, 1111 in order, then SEQ_DONE = 1.
REQ-033 Loop 2 never acknowledges -> FAULT = 1, code 01, FAULT_LOOP = 2 exactly 20 cycles after LOOP_CNTL[2] rises; LOOP_CNTL = 0000 next cycle.
REQ-034 In RUN, LOOP_STATE[1] low for 3 cycles -> no fault; low for 10 cycles -> code 10, FAULT_LOOP = 1.
REQ-035 LOOP_STATE[3] held high in IDLE, then START -> code 11, FAULT_LOOP = 3, LOOP_CNTL stays 0000; FAULT_CLR ignored until state returns low.
REQ-036 STOP and START in the same cycle during ARM idx = 1 -> IDLE, LOOP_CNTL = 0000 next cycle.
REQ-037 RST asserted in RUN -> LOOP_CNTL = 0000 without a clock edge; after release START re-sequences from loop 0.
